// File: rtl/birukee_matrix_loader_if.sv
// DMA read channel and operand-buffer write port of the birukee matrix loader.
// master = loader side, slave = DMA engine / buffer side.
interface birukee_matrix_loader_if #(
  parameter int IN_WIDTH        = 16,
  parameter int MAX_MATRIX_SIZE = 8
);
  localparam int AW = $clog2(MAX_MATRIX_SIZE);

  logic                dma_read_ctrl_valid;
  logic                dma_read_ctrl_ready;
  logic [31:0]         dma_read_ctrl_data_index;
  logic [31:0]         dma_read_ctrl_data_length;
  logic [2:0]          dma_read_ctrl_data_size;
  logic                dma_read_chnl_valid;
  logic [63:0]         dma_read_chnl_data;
  logic                dma_read_chnl_ready;
  logic                buf_wr_en;
  logic                buf_wr_sel;
  logic [AW-1:0]       buf_wr_row;
  logic [AW-1:0]       buf_wr_col;
  logic [IN_WIDTH-1:0] buf_wr_data;

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           buf_wr_en, buf_wr_sel, buf_wr_row, buf_wr_col, buf_wr_data,
    input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data
  );

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
           dma_read_ctrl_data_size, dma_read_chnl_ready,
           buf_wr_en, buf_wr_sel, buf_wr_row, buf_wr_col, buf_wr_data,
    output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data
  );
endinterface

// File: rtl/birukee_matrix_loader.sv
// Loads both N x N operand matrices over the ESP DMA read channel into the systolic
// operand buffers. Define BIRUKEE_LOADER_TRANSPOSE_EN to store matrix 2 column-major.
module birukee_matrix_loader #(
  parameter int IN_WIDTH        = 16,
  parameter int MAX_MATRIX_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [31:0]             conf_info_matrix_size,
  input  logic [31:0]             conf_info_input1,
  input  logic [31:0]             conf_info_input2,
  birukee_matrix_loader_if.master bus,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err
);
  localparam int EPB = 64 / IN_WIDTH;
  localparam int AW  = $clog2(MAX_MATRIX_SIZE);
  localparam int LW  = $clog2(EPB + 1);

  typedef enum logic [2:0] {IDLE, CHECK, REQ1, DATA1, REQ2, DATA2, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   n_q, in1_q, in2_q, len_q;
  logic [31:0]   beats_left, elem_rem;
  logic          err_q;
  logic [LW-1:0] live;
  logic [AW-1:0] row_q, col_q;
  logic [63:0]   hold_q;

  logic          in_data, in_req, wr_fire, beat_fire, req_fire, data_end, n_bad;
  logic [31:0]   nn;
  logic [AW-1:0] n_m1;
  logic [LW-1:0] live_new;

  function automatic logic [31:0] ceil_beats(input logic [31:0] elems);
    return (elems + 32'(EPB - 1)) / 32'(EPB);
  endfunction

  assign in_data  = (state == DATA1) || (state == DATA2);
  assign in_req   = (state == REQ1) || (state == REQ2);
  assign n_bad    = (n_q == 32'd0) || (n_q > 32'(MAX_MATRIX_SIZE));
  assign nn       = n_q * n_q;
  assign n_m1     = AW'(n_q - 32'd1);
  // The last beat of a matrix may carry fewer live elements than EPB.
  assign live_new = (elem_rem >= 32'(EPB)) ? LW'(EPB) : LW'(elem_rem);
  assign wr_fire  = in_data && (live != '0);
  assign req_fire = in_req && bus.dma_read_ctrl_ready;
  assign beat_fire = bus.dma_read_chnl_ready && bus.dma_read_chnl_valid;
  assign data_end = in_data && (beats_left == 32'd0) && (live == LW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = CHECK;
      CHECK:   state_nxt = n_bad ? DONE : REQ1;
      REQ1:    if (req_fire) state_nxt = DATA1;
      DATA1:   if (data_end) state_nxt = REQ2;
      REQ2:    if (req_fire) state_nxt = DATA2;
      DATA2:   if (data_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.dma_read_ctrl_valid       = in_req;
    bus.dma_read_ctrl_data_index  = 32'd0;
    bus.dma_read_ctrl_data_length = 32'd0;
    bus.dma_read_ctrl_data_size   = 3'b011;
    bus.dma_read_chnl_ready       = in_data && (beats_left != 32'd0) &&
                                    ((live == '0) || (live == LW'(1)));
    bus.buf_wr_en                 = wr_fire;
    bus.buf_wr_sel                = 1'b0;
    bus.buf_wr_row                = '0;
    bus.buf_wr_col                = '0;
    bus.buf_wr_data               = '0;
    busy                          = (state != IDLE);
    load_done                     = (state == DONE);
    load_err                      = (state == DONE) && err_q;
    if (in_req) begin
      bus.dma_read_ctrl_data_index  = (state == REQ2) ? in2_q : in1_q;
      bus.dma_read_ctrl_data_length = len_q;
    end
    if (wr_fire) begin
      bus.buf_wr_sel  = (state == DATA2);
      bus.buf_wr_row  = row_q;
      bus.buf_wr_col  = col_q;
      bus.buf_wr_data = hold_q[IN_WIDTH-1:0];
`ifdef BIRUKEE_LOADER_TRANSPOSE_EN
      if (state == DATA2) begin
        bus.buf_wr_row = col_q;
        bus.buf_wr_col = row_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q        <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      len_q      <= '0;
      beats_left <= '0;
      elem_rem   <= '0;
      err_q      <= 1'b0;
      live       <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      case (state)
        IDLE: if (load_start) begin
          n_q   <= conf_info_matrix_size;
          in1_q <= conf_info_input1;
          in2_q <= conf_info_input2;
          err_q <= 1'b0;
        end
        CHECK: begin
          err_q      <= n_bad;
          len_q      <= ceil_beats(nn);
          beats_left <= ceil_beats(nn);
          elem_rem   <= nn;
          live       <= '0;
          row_q      <= '0;
          col_q      <= '0;
        end
        DONE: err_q <= 1'b0;
        default: ;
      endcase
      if (beat_fire) begin
        beats_left <= beats_left - 32'd1;
        elem_rem   <= elem_rem - 32'(live_new);
        live       <= live_new;
      end else if (wr_fire) begin
        live <= live - LW'(1);
      end
      if (wr_fire) begin
        if (col_q == n_m1) begin
          col_q <= '0;
          row_q <= row_q + AW'(1);
        end else begin
          col_q <= col_q + AW'(1);
        end
      end
      // Matrix 2 restarts at (0,0) with a fresh burst budget.
      if (data_end && (state == DATA1)) begin
        beats_left <= len_q;
        elem_rem   <= nn;
        row_q      <= '0;
        col_q      <= '0;
      end
    end
  end

  // Beat holding register: element 0 sits in the low bits and is shifted out per write.
  always_ff @(posedge clk) begin
    if (beat_fire)    hold_q <= bus.dma_read_chnl_data;
    else if (wr_fire) hold_q <= hold_q >> IN_WIDTH;
  end
endmodule

// File: tb/tb_birukee_matrix_loader.sv
// Randomized self-checking bench for birukee_matrix_loader with a DMA responder and
// an element-level reference model (row-major, matrix 2 swapped when transposing).
`timescale 1ns/1ps
module tb_birukee_matrix_loader;
  localparam int IN_WIDTH = 16;
  localparam int MAXN     = 8;
  localparam int EPB      = 64 / IN_WIDTH;
  localparam int AW       = $clog2(MAXN);

  typedef struct packed {
    logic                sel;
    logic [AW-1:0]       row;
    logic [AW-1:0]       col;
    logic [IN_WIDTH-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] length;
    logic [2:0]  size;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [31:0] conf_n = '0, conf_in1 = '0, conf_in2 = '0;
  logic        busy, load_done, load_err;

  birukee_matrix_loader_if #(.IN_WIDTH(IN_WIDTH), .MAX_MATRIX_SIZE(MAXN)) bus ();

  birukee_matrix_loader #(.IN_WIDTH(IN_WIDTH), .MAX_MATRIX_SIZE(MAXN)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .load_start            (load_start),
    .conf_info_matrix_size (conf_n),
    .conf_info_input1      (conf_in1),
    .conf_info_input2      (conf_in2),
    .bus                   (bus),
    .busy                  (busy),
    .load_done             (load_done),
    .load_err              (load_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0, start_cyc = 0;
  wr_t  wr_q[$], exp_q[$];
  req_t req_q[$];
  logic [63:0] beat_q[$];
  logic [IN_WIDTH-1:0] mats [2][64];
  int cur_n = 0;
  logic [31:0] cur_in1 = '0;
  int done_cnt, err_cnt, done_cyc, first_valid_cyc, valid_cycles, stab_err;
  int wr_first [2];
  int wr_last  [2];
  logic busy_after_done, prev_done;
  int ctrl_delay = 0;
  bit chnl_gaps = 1'b0;
  bit timed_out;

  // Monitor and DMA responder share one process so sampling precedes driving.
  initial begin
    int wait_cnt;
    bit pend;
    logic [31:0] hold_idx, hold_len;
    wait_cnt = 0; pend = 1'b0; hold_idx = '0; hold_len = '0;
    bus.dma_read_ctrl_ready = 1'b0;
    bus.dma_read_chnl_valid = 1'b0;
    bus.dma_read_chnl_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.buf_wr_en) begin
        wr_q.push_back(wr_t'{bus.buf_wr_sel, bus.buf_wr_row, bus.buf_wr_col, bus.buf_wr_data});
        if (wr_first[int'(bus.buf_wr_sel)] < 0) wr_first[int'(bus.buf_wr_sel)] = cyc;
        wr_last[int'(bus.buf_wr_sel)] = cyc;
      end
      if (prev_done) busy_after_done = busy;
      prev_done = load_done;
      if (load_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (load_err) err_cnt++;
      end
      if (bus.dma_read_ctrl_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (!rst) begin
        bus.dma_read_ctrl_ready = 1'b0;
        bus.dma_read_chnl_valid = 1'b0;
        beat_q.delete();
        wait_cnt = 0;
        pend = 1'b0;
      end else begin
        if (bus.dma_read_ctrl_valid) begin
          if (wait_cnt == 0) begin
            hold_idx = bus.dma_read_ctrl_data_index;
            hold_len = bus.dma_read_ctrl_data_length;
          end else if (bus.dma_read_ctrl_data_index !== hold_idx ||
                       bus.dma_read_ctrl_data_length !== hold_len) begin
            stab_err++;
          end
          if (wait_cnt >= ctrl_delay) begin
            int m;
            bus.dma_read_ctrl_ready = 1'b1;
            req_q.push_back(req_t'{bus.dma_read_ctrl_data_index,
                                   bus.dma_read_ctrl_data_length,
                                   bus.dma_read_ctrl_data_size});
            m = (bus.dma_read_ctrl_data_index == cur_in1) ? 0 : 1;
            for (int b = 0; b < int'(bus.dma_read_ctrl_data_length) && b < 64; b++) begin
              logic [63:0] beat;
              beat = {$urandom, $urandom};
              for (int k = 0; k < EPB; k++)
                if (b * EPB + k < cur_n * cur_n) beat[k*IN_WIDTH +: IN_WIDTH] = mats[m][b*EPB+k];
              beat_q.push_back(beat);
            end
            wait_cnt = 0;
          end else begin
            bus.dma_read_ctrl_ready = 1'b0;
            wait_cnt++;
          end
        end else begin
          bus.dma_read_ctrl_ready = 1'b0;
        end
        if (!pend) begin
          if (beat_q.size() > 0 && (!chnl_gaps || $urandom_range(0, 1) == 1)) begin
            bus.dma_read_chnl_data  = beat_q[0];
            bus.dma_read_chnl_valid = 1'b1;
          end else begin
            bus.dma_read_chnl_data  = {$urandom, $urandom};
            bus.dma_read_chnl_valid = 1'b0;
          end
        end
        if (bus.dma_read_chnl_valid && bus.dma_read_chnl_ready) begin
          beat_q.delete(0);
          pend = 1'b0;
        end else begin
          pend = bus.dma_read_chnl_valid;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete(); req_q.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    valid_cycles = 0; stab_err = 0;
    wr_first[0] = -1; wr_first[1] = -1; wr_last[0] = -1; wr_last[1] = -1;
    busy_after_done = 1'bx; prev_done = 1'b0;
  endtask

  // Reference: element i of matrix m lands at (i/N, i%N), value mats[m][i].
  task automatic prep(input int n, input logic [31:0] i1, input bit fixed2);
    int r, c, t;
    cur_n = n; cur_in1 = i1;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 64; i++) mats[m][i] = IN_WIDTH'($urandom);
    if (fixed2) for (int i = 0; i < 4; i++) mats[1][i] = IN_WIDTH'(i + 1);
    exp_q.delete();
    if (n >= 1 && n <= MAXN)
      for (int m = 0; m < 2; m++)
        for (int i = 0; i < n * n; i++) begin
          r = i / n; c = i % n;
`ifdef BIRUKEE_LOADER_TRANSPOSE_EN
          if (m == 1) begin t = r; r = c; c = t; end
`endif
          exp_q.push_back(wr_t'{m[0], r[AW-1:0], c[AW-1:0], mats[m][i]});
        end
    clear_log();
  endtask

  task automatic start(input int n, input logic [31:0] i1, input logic [31:0] i2);
    conf_n = n; conf_in1 = i1; conf_in2 = i2;
    load_start = 1'b1;
    start_cyc = cyc;
    tick();
    load_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k, d0;
    k = 0; d0 = done_cnt;
    while (done_cnt == d0 && k < limit) begin tick(); k++; end
    timed_out = (done_cnt == d0);
    tick(); tick();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    tick(); tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++;
    if ({load_done, load_err} !== 2'b00) $display("FAIL reset_done_err got %b want 00", {load_done, load_err}); else pass_cnt++;
    total_cnt++;
    if ({bus.dma_read_ctrl_valid, bus.dma_read_chnl_ready} !== 2'b00)
      $display("FAIL reset_dma got %b want 00", {bus.dma_read_ctrl_valid, bus.dma_read_chnl_ready});
    else pass_cnt++;
    total_cnt++;
    if ({bus.buf_wr_en, bus.buf_wr_sel, bus.buf_wr_row, bus.buf_wr_col, bus.buf_wr_data} !== '0)
      $display("FAIL reset_buf got %h want 0", {bus.buf_wr_en, bus.buf_wr_sel, bus.buf_wr_row, bus.buf_wr_col, bus.buf_wr_data});
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic_n4();
    ctrl_delay = 0; chnl_gaps = 1'b0;
    prep(4, 32'h100, 1'b0);
    start(4, 32'h100, 32'h200);
    wait_done(400);
    total_cnt++;
    if (timed_out) $display("FAIL n4_timeout got no load_done want load_done"); else pass_cnt++;
    total_cnt++;
    if (req_q.size() !== 2) $display("FAIL n4_req_count got %0d want 2", req_q.size()); else pass_cnt++;
    if (req_q.size() >= 2) begin
      total_cnt++;
      if (req_q[0] !== req_t'{32'h100, 32'd4, 3'd3}) $display("FAIL n4_req1 got %h want %h", req_q[0], req_t'{32'h100, 32'd4, 3'd3}); else pass_cnt++;
      total_cnt++;
      if (req_q[1] !== req_t'{32'h200, 32'd4, 3'd3}) $display("FAIL n4_req2 got %h want %h", req_q[1], req_t'{32'h200, 32'd4, 3'd3}); else pass_cnt++;
    end
    total_cnt++;
    if (first_valid_cyc !== start_cyc + 2) $display("FAIL n4_valid_latency got %0d want %0d", first_valid_cyc, start_cyc + 2); else pass_cnt++;
    total_cnt++;
    if (wr_q.size() !== exp_q.size()) $display("FAIL n4_wr_count got %0d want %0d", wr_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total_cnt++;
      if (wr_q[i] !== exp_q[i]) $display("FAIL n4_wr[%0d] got %h want %h", i, wr_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++;
    if (wr_last[0] - wr_first[0] + 1 !== 16) $display("FAIL n4_m1_span got %0d want 16", wr_last[0] - wr_first[0] + 1); else pass_cnt++;
    total_cnt++;
    if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) $display("FAIL n4_done_err got %0d/%0d want 1/0", done_cnt, err_cnt); else pass_cnt++;
    total_cnt++;
    if (done_cyc !== wr_last[1] + 1) $display("FAIL n4_done_latency got %0d want %0d", done_cyc, wr_last[1] + 1); else pass_cnt++;
    total_cnt++;
    if (busy_after_done !== 1'b0) $display("FAIL n4_busy_after_done got %b want 0", busy_after_done); else pass_cnt++;
  endtask

  task automatic test_partial_beat_n3();
    ctrl_delay = 0; chnl_gaps = 1'b0;
    prep(3, 32'h10, 1'b0);
    start(3, 32'h10, 32'h20);
    wait_done(400);
    total_cnt++;
    if (timed_out) $display("FAIL n3_timeout got no load_done want load_done"); else pass_cnt++;
    total_cnt++;
    if (req_q.size() !== 2) $display("FAIL n3_req_count got %0d want 2", req_q.size()); else pass_cnt++;
    for (int i = 0; i < req_q.size(); i++) begin
      total_cnt++;
      if (req_q[i].length !== 32'd3) $display("FAIL n3_len[%0d] got %0d want 3", i, req_q[i].length); else pass_cnt++;
    end
    total_cnt++;
    if (wr_q.size() !== 18) $display("FAIL n3_wr_count got %0d want 18", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total_cnt++;
      if (wr_q[i] !== exp_q[i]) $display("FAIL n3_wr[%0d] got %h want %h", i, wr_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++;
    if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) $display("FAIL n3_done_err got %0d/%0d want 1/0", done_cnt, err_cnt); else pass_cnt++;
  endtask

  task automatic test_stall();
    int n;
    for (int rep = 0; rep < 2; rep++) begin
      n = $urandom_range(5, 8);
      ctrl_delay = 5; chnl_gaps = 1'b1;
      prep(n, 32'h100, 1'b0);
      start(n, 32'h100, 32'h200);
      wait_done(2000);
      total_cnt++;
      if (timed_out) $display("FAIL stall_timeout n=%0d got no load_done want load_done", n); else pass_cnt++;
      total_cnt++;
      if (stab_err !== 0) $display("FAIL stall_ctrl_stable got %0d changes want 0", stab_err); else pass_cnt++;
      total_cnt++;
      if (req_q.size() !== 2) $display("FAIL stall_req_count got %0d want 2", req_q.size()); else pass_cnt++;
      for (int i = 0; i < req_q.size(); i++) begin
        total_cnt++;
        if (req_q[i].length !== 32'((n * n + EPB - 1) / EPB))
          $display("FAIL stall_len[%0d] got %0d want %0d", i, req_q[i].length, (n * n + EPB - 1) / EPB);
        else pass_cnt++;
      end
      total_cnt++;
      if (wr_q.size() !== exp_q.size()) $display("FAIL stall_wr_count got %0d want %0d", wr_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        total_cnt++;
        if (wr_q[i] !== exp_q[i]) $display("FAIL stall_wr[%0d] got %h want %h", i, wr_q[i], exp_q[i]); else pass_cnt++;
      end
      total_cnt++;
      if (done_cyc !== wr_last[1] + 1) $display("FAIL stall_done_latency got %0d want %0d", done_cyc, wr_last[1] + 1); else pass_cnt++;
    end
    ctrl_delay = 0; chnl_gaps = 1'b0;
  endtask

  task automatic test_illegal_n();
    int nv [2];
    nv[0] = 0; nv[1] = MAXN + 1;
    for (int j = 0; j < 2; j++) begin
      prep(nv[j], 32'h700, 1'b0);
      start(nv[j], 32'h700, 32'h800);
      wait_done(20);
      total_cnt++;
      if (done_cyc !== start_cyc + 2) $display("FAIL illegal_done_cycle n=%0d got %0d want %0d", nv[j], done_cyc, start_cyc + 2); else pass_cnt++;
      total_cnt++;
      if ({done_cnt, err_cnt} !== {32'd1, 32'd1}) $display("FAIL illegal_done_err n=%0d got %0d/%0d want 1/1", nv[j], done_cnt, err_cnt); else pass_cnt++;
      total_cnt++;
      if (valid_cycles !== 0) $display("FAIL illegal_no_req n=%0d got %0d valid cycles want 0", nv[j], valid_cycles); else pass_cnt++;
      total_cnt++;
      if (wr_q.size() !== 0) $display("FAIL illegal_no_wr n=%0d got %0d writes want 0", nv[j], wr_q.size()); else pass_cnt++;
    end
  endtask

  task automatic test_restart_and_reset();
    int k, nwr, nreq;
    ctrl_delay = 0; chnl_gaps = 1'b1;
    prep(4, 32'h300, 1'b0);
    start(4, 32'h300, 32'h400);
    k = 0;
    while (wr_q.size() < 3 && k < 500) begin tick(); k++; end
    start(2, 32'h500, 32'h600);
    k = 0;
    while (wr_first[1] < 0 && k < 1000) begin tick(); k++; end
    total_cnt++;
    if (wr_first[1] < 0) $display("FAIL restart_reach_data2 got no matrix-2 write want one"); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({busy, load_done, load_err, bus.dma_read_ctrl_valid, bus.dma_read_chnl_ready} !== 5'b0)
      $display("FAIL midreset_ctrl got %b want 00000", {busy, load_done, load_err, bus.dma_read_ctrl_valid, bus.dma_read_chnl_ready});
    else pass_cnt++;
    total_cnt++;
    if ({bus.buf_wr_en, bus.buf_wr_sel, bus.buf_wr_row, bus.buf_wr_col, bus.buf_wr_data} !== '0)
      $display("FAIL midreset_buf got %h want 0", {bus.buf_wr_en, bus.buf_wr_sel, bus.buf_wr_row, bus.buf_wr_col, bus.buf_wr_data});
    else pass_cnt++;
    nwr = wr_q.size(); nreq = req_q.size();
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({wr_q.size(), req_q.size()} !== {nwr, nreq})
      $display("FAIL midreset_quiet got %0d wr/%0d req want %0d/%0d", wr_q.size(), req_q.size(), nwr, nreq);
    else pass_cnt++;
    total_cnt++;
    if (req_q.size() !== 2) $display("FAIL restart_req_count got %0d want 2", req_q.size()); else pass_cnt++;
    if (req_q.size() >= 2) begin
      total_cnt++;
      if ({req_q[0].index, req_q[1].index} !== {32'h300, 32'h400})
        $display("FAIL restart_ignored got %h/%h want 300/400", req_q[0].index, req_q[1].index);
      else pass_cnt++;
    end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      total_cnt++;
      if (wr_q[i] !== exp_q[i]) $display("FAIL restart_wr[%0d] got %h want %h", i, wr_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++;
    if ({done_cnt, busy} !== {32'd0, 1'b0}) $display("FAIL midreset_idle got done=%0d busy=%b want 0/0", done_cnt, busy); else pass_cnt++;
    chnl_gaps = 1'b0;
  endtask

  task automatic test_n2_pattern();
    wr_t tbl [4];
`ifdef BIRUKEE_LOADER_TRANSPOSE_EN
    tbl[0] = wr_t'{1'b1, 3'd0, 3'd0, 16'd1};
    tbl[1] = wr_t'{1'b1, 3'd1, 3'd0, 16'd2};
    tbl[2] = wr_t'{1'b1, 3'd0, 3'd1, 16'd3};
    tbl[3] = wr_t'{1'b1, 3'd1, 3'd1, 16'd4};
`else
    tbl[0] = wr_t'{1'b1, 3'd0, 3'd0, 16'd1};
    tbl[1] = wr_t'{1'b1, 3'd0, 3'd1, 16'd2};
    tbl[2] = wr_t'{1'b1, 3'd1, 3'd0, 16'd3};
    tbl[3] = wr_t'{1'b1, 3'd1, 3'd1, 16'd4};
`endif
    ctrl_delay = 0; chnl_gaps = 1'b0;
    prep(2, 32'h40, 1'b1);
    start(2, 32'h40, 32'h80);
    wait_done(200);
    total_cnt++;
    if (timed_out) $display("FAIL n2_timeout got no load_done want load_done"); else pass_cnt++;
    total_cnt++;
    if (wr_q.size() !== 8) $display("FAIL n2_wr_count got %0d want 8", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      total_cnt++;
      if (wr_q[i] !== exp_q[i]) $display("FAIL n2_wr[%0d] got %h want %h", i, wr_q[i], exp_q[i]); else pass_cnt++;
    end
    for (int i = 0; i < 4 && i + 4 < wr_q.size(); i++) begin
      total_cnt++;
      if (wr_q[i+4] !== tbl[i]) $display("FAIL n2_b_table[%0d] got %h want %h", i, wr_q[i+4], tbl[i]); else pass_cnt++;
    end
    total_cnt++;
    if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) $display("FAIL n2_done_err got %0d/%0d want 1/0", done_cnt, err_cnt); else pass_cnt++;
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic_n4();
    test_partial_beat_n3();
    test_stall();
    test_illegal_n();
    test_restart_and_reset();
    test_n2_pattern();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end
endmodule
